// File: rtl/rv_core_pkg.sv
// Shared rv32 core types and constants used by the register file and scoreboard.
package rv_core_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned ZERO_REG   = 0;

    typedef logic [XLEN_DEF-1:0]   xlen_t;
    typedef logic [REG_AW_DEF-1:0] reg_addr_t;

endpackage : rv_core_pkg

// File: rtl/rv_scoreboard.sv
// Per-register pending-write scoreboard: issue sets busy, writeback clears it, issue wins on collision.
module rv_scoreboard
    import rv_core_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                clr_valid,
    input  logic [AW-1:0]       clr_rd,
    output logic [NUM_REGS-1:0] busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                set_en;
    logic                clr_en;

    assign set_en = iss_valid && (iss_rd != AW'(ZERO_REG));
    assign clr_en = clr_valid && (clr_rd != AW'(ZERO_REG));

    // Clear is applied before set so a same-edge new producer keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_en) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule : rv_scoreboard

// File: rtl/rv_regfile_sb.sv
// Multi-read, single-write register file with x0 hardwired to zero and an integrated busy scoreboard.
// Optional write-through forwarding is enabled by defining RV_REGFILE_BYPASS_EN.
module rv_regfile_sb
    import rv_core_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned AW       = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RD*AW-1:0]   raddr,
    output logic [NUM_RD*XLEN-1:0] rdata,
    output logic [NUM_RD-1:0]      rbusy,
    input  logic                   WE,
    input  logic [AW-1:0]          waddr,
    input  logic [XLEN-1:0]        wdata,
    input  logic                   iss_valid,
    input  logic [AW-1:0]          iss_rd,
    output logic [NUM_REGS-1:0]    busy_vec
);

    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] regs_d [NUM_REGS];
    logic            wr_en;

    assign wr_en = WE && (waddr != AW'(ZERO_REG));

    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (wr_en) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    rv_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .clr_valid (WE),
        .clr_rd    (waddr),
        .busy_vec  (busy_vec)
    );

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra = raddr[g*AW +: AW];

        always_comb begin
            rd = regs_q[ra];
            rb = busy_vec[ra];
            if (ra == AW'(ZERO_REG)) begin
                rd = '0;
                rb = 1'b0;
            end
`ifdef RV_REGFILE_BYPASS_EN
            // Forward the writeback value; only a same-cycle reissue keeps the port busy.
            if (wr_en && (waddr == ra)) begin
                rd = wdata;
                rb = iss_valid && (iss_rd == ra);
            end
`endif
        end

        assign rdata[g*XLEN +: XLEN] = rd;
        assign rbusy[g]              = rb;
    end

endmodule : rv_regfile_sb

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
- Parametrised successor to the single-write, two-read RegFile used by the rv32 5-stage core.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Hardwires x0 to zero.
- Adds a per-register pending-write scoreboard. Decode sets a register's busy bit at issue; writeback clears it. The hazard unit uses the busy bits to stall instead of keeping its own tracking.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NUM_REGS), register address width (derived; do not override).
- NUM_RD, 2, number of read ports, 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-high.
- raddr  in  NUM_RD*AW  read addresses, flattened; port i occupies [i*AW +: AW].
- rdata  out  NUM_RD*XLEN  read data, flattened the same way.
- rbusy  out  NUM_RD  busy bit of the register addressed by each read port.
- WE  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  XLEN  write data.
- iss_valid  in  1  an instruction issued this cycle will write iss_rd.
- iss_rd  in  AW  destination register of the issued instruction.
- busy_vec  out  NUM_REGS  full scoreboard, for debug and the hazard unit.

Behaviour:
- Reset, asynchronous, while rst=1:
  - all registers are 0 and busy_vec is 0.
  - rdata is therefore 0 and rbusy is 0.
  - Reset asserted mid-operation discards in-flight state immediately, independent of clk.
- Reads are combinational with zero latency: rdata[i] = regs[raddr[i]].
  - raddr[i]=0 always gives 0 and rbusy[i]=0.
- Write: on posedge clk with WE=1 and waddr!=0, regs[waddr] <= wdata.
  - WE with waddr=0 is ignored and has no effect on the scoreboard.
- Scoreboard, per register r != 0, evaluated on posedge clk:
  - set = iss_valid && iss_rd==r.
  - clr = WE && waddr==r.
  - set=1 makes busy[r] 1. This includes the case where clr is also 1: the new producer wins.
  - set=0, clr=1 makes busy[r] 0.
  - Otherwise busy[r] holds.
- iss_valid with iss_rd=0 is ignored; busy[0] is constant 0.
- Setting an already-busy register keeps it busy. This supports WAW in order; the core never has two writers to the same register in flight out of order.
- Clearing a non-busy register is legal and leaves it 0. The write itself still updates the register.
- rbusy[i] = busy_vec[raddr[i]], subject to the bypass rule below.
- No other state; there is no overflow or wrap condition.

Optional Feature:
- Macro: RV_REGFILE_BYPASS_EN.
- Defined (write-through forwarding):
  - If WE=1, waddr!=0 and raddr[i]==waddr, rdata[i]=wdata in the same cycle.
  - rbusy[i]=0 in that cycle, unless iss_valid && iss_rd==raddr[i].
  - This removes the write-back/decode hazard bubble.
- Undefined:
  - rdata[i] shows the old value until after the edge.
  - rbusy[i] stays 1 during the writeback cycle, so the hazard unit stalls one extra cycle.
- Register storage and scoreboard update are identical in both builds.

Decomposition:
- Package rv_core_pkg holds:
  - XLEN_DEF=32, REG_AW_DEF=5, ZERO_REG=0.
  - typedef xlen_t (logic [XLEN_DEF-1:0]).
  - typedef reg_addr_t (logic [REG_AW_DEF-1:0]).
- Sub-module rv_scoreboard (NUM_REGS, AW):
  - inputs clk, rst, iss_valid, iss_rd, clr_valid, clr_rd.
  - output busy_vec.
  - Instantiated once.
- Storage and read muxing, including the bypass logic, stay in the top module.

Test Plan:
- Reset test: write regs 1..31 with values, then pulse rst asynchronously mid-cycle. Expect all rdata=0 and busy_vec=0 immediately, before the next clk edge.
- x0 test:
  - WE=1, waddr=0, wdata=32'hDEADBEEF, then raddr0=0: expect rdata0=0.
  - iss_valid=1, iss_rd=0: expect busy_vec[0]=0.
- Write/read test:
  - Write x5=32'h7, x6=32'h8 on consecutive edges; then raddr0=5, raddr1=6: expect rdata=7 and 8.
  - With NUM_RD=4, all four ports read x6: expect 8 on every port.
- Scoreboard test: iss x3 at cycle 0, expect busy[3]=1 from cycle 1. WE x3=32'h11 at cycle 4, expect busy[3]=0 from cycle 5 and rdata=11.
- Set/clear collision: same edge has WE x3 and iss_valid x3. Expect busy[3] stays 1 and regs[3] is updated.
- Bypass test:
  - With RV_REGFILE_BYPASS_EN, WE x7=32'h2A and raddr0=7 in the same cycle: expect rdata0=2A and rbusy0=0.
  - Without the macro: expect the old value and rbusy0=1 in that cycle, then 2A after the edge.
